regfile_wb_sched: RTL
=====================

Name: regfile_wb_sched

Overview:
- Write-back scheduler and scoreboard for the 32x32 register file (x0 hardwired to zero, one write port, two read ports).
- Arbitrates two write-back requesters onto the single write port:
  - port A: ALU/execute result, high priority.
  - port B: load/memory result, buffered in a small FIFO, with an anti-starvation override.
- Tracks one busy bit per architectural register and flags read-after-write hazards to the issue stage.
- Sits between execute/memory and the register file write port.

Parameters:
- DEPTH, 2, port-B FIFO entries; power of 2, at least 2.
- MAX_WAIT, 4, cycles a B head entry may lose arbitration before it is forced to win; at least 1.

Ports:
- clk in 1: clock.
- rst_n in 1: synchronous reset, active-high (1 = reset), sampled on the rising edge of clk.
- a_valid in 1: port A write-back request.
- a_ready out 1: port A accepted this cycle.
- a_rd in 5: port A destination register.
- a_data in 32: port A result.
- b_valid in 1: port B write-back request.
- b_ready out 1: port B FIFO can accept.
- b_rd in 5: port B destination register.
- b_data in 32: port B result.
- iss_valid in 1: an instruction issues this cycle.
- iss_rd in 5: destination of the issuing instruction.
- rs1 in 5: source 1 register for the hazard check.
- rs2 in 5: source 2 register for the hazard check.
- hazard out 1: rs1 or rs2 is busy.
- rf_wen out 1: register file write enable.
- rf_rd out 5: register file write address.
- rf_data out 32: register file write data.
- busy_vec out 32: scoreboard state; bit 0 is always 0.

Behaviour:
- Reset: FIFO empty, wait counter 0, busy_vec 0, rf_wen 0, rf_rd 0, rf_data 0. a_ready and b_ready follow the combinational equations below from the reset state, so both are 1 after reset.
- Port B enqueue: occurs when b_valid and b_ready. b_ready = FIFO not full.
  - Simultaneous enqueue and dequeue on a full FIFO is not allowed; b_ready stays 0 when full.
- Arbitration is evaluated each cycle:
  - force = FIFO not empty and wait counter at or above MAX_WAIT.
  - If force: B head wins and a_ready = 0.
  - Else if a_valid: A wins and a_ready = 1.
  - Else if FIFO not empty: B head wins.
  - When force is not active, a_ready = 1 even if a_valid = 0.
- A B enqueue never bypasses the FIFO. A winning B write always comes from the existing head, so B latency is at least 2 cycles (enqueue, then write).
- Wait counter:
  - Increments when the FIFO is non-empty and A wins.
  - Clears when B wins or the FIFO is empty.
  - Saturates at MAX_WAIT.
- Write-back output is registered with one cycle latency: on the edge after a grant, rf_wen = 1 and rf_rd / rf_data = the winner's fields.
  - With no grant, rf_wen = 0 and rf_rd / rf_data hold their previous values.
  - A grant with rd = 0 still drives rf_wen = 1; the register file ignores x0.
- Scoreboard, updated on the same edge:
  - Set busy[iss_rd] when iss_valid and iss_rd != 0.
  - Clear busy[rd] for the granted write.
  - Set and clear of the same register in the same cycle: set wins (a newer producer is pending).
  - busy[0] is held at 0.
- hazard = (rs1 != 0 and busy[rs1]) or (rs2 != 0 and busy[rs2]). Combinational from the registered busy_vec. No forwarding from the write being performed this cycle.
- FIFO pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- Reset asserted mid-operation: FIFO contents are discarded, and pending busy bits and the wait counter clear on that edge. No write issues on the reset edge or on the edge after it.

Decomposition:
- Shared constants in the existing constants include:
  - the zero word.
  - REG_ADDR_W = 5.
  - XLEN = 32.
- Sub-module wb_fifo: DEPTH entries of 37 bits ({rd, data}) with push, pop, full, empty, and a head output.
- Arbiter, wait counter, output register and scoreboard live in the top.

Test Plan:
- Reset then single A: a_valid=1, a_rd=5, a_data=0xDEADBEEF for one cycle -> next cycle rf_wen=1, rf_rd=5, rf_data=0xDEADBEEF; a_ready=1.
- Single B: b_valid=1, b_rd=7, b_data=0x12345678 with A idle -> write of x7 = 0x12345678 two cycles after enqueue; b_ready=1 throughout.
- Starvation: enqueue B (rd=9), hold a_valid=1 continuously -> A wins 4 cycles, then a_ready=0 for one cycle and x9 is written; A resumes the next cycle.
- FIFO full: enqueue 2 B entries while A is continuously valid -> b_ready=0 until the first B dequeue; no entry is lost, order is preserved.
- Scoreboard: iss_valid with iss_rd=3, then rs1=3 -> hazard=1 until the x3 write-back edge, then 0. Same-cycle issue of rd=3 and write-back of rd=3 -> busy[3] stays 1. iss_rd=0 or rs1=0 never raises hazard.
- Reset mid-flight: 2 B entries queued, busy[4] set, rst_n=1 -> no rf_wen afterwards, busy_vec=0, b_ready=1.

Source files
------------

// File: rtl/regfile_wb_sched_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_sched_pkg
// Shared widths, types and constants for the register-file write-back
// scheduler: register address / data word types, the 37-bit queued
// write-back entry, and the arbitration grant encoding.
// -----------------------------------------------------------------------------
package regfile_wb_sched_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       word_t;

  localparam word_t ZERO_WORD = '0;

  // One queued load result: destination register above the data word.
  typedef struct packed {
    reg_addr_t rd;
    word_t     data;
  } wb_entry_t;

  // Which requester owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_A    = 2'd1,
    GRANT_B    = 2'd2
  } grant_e;

endpackage

// File: rtl/regfile_wb_sched_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_sched_if
// Bundles every non-clock signal of the write-back scheduler.
//   Port A  : a_valid/a_ready/a_rd/a_data   (execute result, high priority)
//   Port B  : b_valid/b_ready/b_rd/b_data   (load result, queued)
//   Issue   : iss_valid/iss_rd, rs1/rs2 -> hazard
//   RF port : rf_wen/rf_rd/rf_data, plus busy_vec scoreboard view
// master = pipeline side driving requests; slave = the scheduler.
// -----------------------------------------------------------------------------
interface regfile_wb_sched_if;
  import regfile_wb_sched_pkg::*;

  logic      a_valid;
  logic      a_ready;
  reg_addr_t a_rd;
  word_t     a_data;

  logic      b_valid;
  logic      b_ready;
  reg_addr_t b_rd;
  word_t     b_data;

  logic      iss_valid;
  reg_addr_t iss_rd;
  reg_addr_t rs1;
  reg_addr_t rs2;
  logic      hazard;

  logic      rf_wen;
  reg_addr_t rf_rd;
  word_t     rf_data;
  logic [NUM_REGS-1:0] busy_vec;

  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    output iss_valid, iss_rd, rs1, rs2,
    input  a_ready, b_ready, hazard,
    input  rf_wen, rf_rd, rf_data, busy_vec
  );

  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    input  iss_valid, iss_rd, rs1, rs2,
    output a_ready, b_ready, hazard,
    output rf_wen, rf_rd, rf_data, busy_vec
  );

endinterface

// File: rtl/regfile_wb_sched_wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Small synchronous FIFO holding queued port-B write-backs ({rd, data}).
// Ports:
//   clk, rst_n    : clock; rst_n is an active-HIGH synchronous reset
//   i_push/i_push_data : enqueue (ignored when full)
//   i_pop         : dequeue the head (ignored when empty)
//   o_head        : current head entry (valid when !o_empty)
//   o_full/o_empty: occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module wb_fifo
  import regfile_wb_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  wb_entry_t i_push_data,
  input  logic      i_pop,
  output wb_entry_t o_head,
  output logic      o_full,
  output logic      o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; clearing the count and pointers
  // already makes stale entries unreachable, and un-reset arrays map to RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// -----------------------------------------------------------------------------
// regfile_wb_sched
// Write-back scheduler and scoreboard in front of the 32x32 register file.
// Ports:
//   clk   : clock
//   rst_n : synchronous reset, active-HIGH despite its name
//   bus   : regfile_wb_sched_if.slave (A/B requests, issue/hazard, RF write)
// Port A (execute) normally wins the single write port; port B (loads) is
// queued in wb_fifo and forced through once its head has lost MAX_WAIT
// times. Writes are registered one cycle after the grant. One busy bit per
// register is set on issue and cleared by the granted write-back.
// -----------------------------------------------------------------------------
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  regfile_wb_sched_if.slave bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  wb_entry_t           w_head;
  wb_entry_t           w_push_data;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_force;
  grant_e              w_grant;
  reg_addr_t           w_wr_rd;
  word_t               w_wr_data;
  logic [NUM_REGS-1:0] w_busy_next;

  logic [WAIT_W-1:0]   r_wait;
  logic                r_rf_wen;
  reg_addr_t           r_rf_rd;
  word_t               r_rf_data;
  logic [NUM_REGS-1:0] r_busy;

  // ---------------------------------------------------------------- port B
  // A new load never bypasses the queue: it can only win from the head.
  assign w_push      = bus.b_valid && !w_full;
  assign w_push_data = '{rd: bus.b_rd, data: bus.b_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_grant == GRANT_B),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // ------------------------------------------------------------ arbitration
  assign w_force     = !w_empty && (r_wait >= WAIT_W'(MAX_WAIT));
  assign bus.a_ready = !w_force;
  assign bus.b_ready = !w_full;

  // NOTE: every output of a combinational block gets a default first, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_grant   = GRANT_NONE;
    w_wr_rd   = w_head.rd;
    w_wr_data = w_head.data;
    if (w_force) begin
      w_grant = GRANT_B;
    end else if (bus.a_valid) begin
      w_grant   = GRANT_A;
      w_wr_rd   = bus.a_rd;
      w_wr_data = bus.a_data;
    end else if (!w_empty) begin
      w_grant = GRANT_B;
    end
  end

  // Counts how many times the current B head has been passed over by A.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_wait <= '0;
    end else if (w_empty || (w_grant == GRANT_B)) begin
      r_wait <= '0;
    end else if (r_wait < WAIT_W'(MAX_WAIT)) begin
      r_wait <= r_wait + WAIT_W'(1);
    end
  end

  // ------------------------------------------------------ write-back output
  // Address/data hold between writes; only the enable pulses.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_rf_wen  <= 1'b0;
      r_rf_rd   <= '0;
      r_rf_data <= ZERO_WORD;
    end else begin
      r_rf_wen <= (w_grant != GRANT_NONE);
      if (w_grant != GRANT_NONE) begin
        r_rf_rd   <= w_wr_rd;
        r_rf_data <= w_wr_data;
      end
    end
  end

  assign bus.rf_wen  = r_rf_wen;
  assign bus.rf_rd   = r_rf_rd;
  assign bus.rf_data = r_rf_data;

  // ------------------------------------------------------------- scoreboard
  // Set is applied after clear: a newly issued producer of the same register
  // must stay pending even while an older result is written back.
  always_comb begin
    w_busy_next = r_busy;
    if (w_grant != GRANT_NONE) w_busy_next[w_wr_rd] = 1'b0;
    if (bus.iss_valid && (bus.iss_rd != '0)) w_busy_next[bus.iss_rd] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign bus.busy_vec = r_busy;

  // No forwarding: a write happening this cycle does not hide the hazard.
  assign bus.hazard = ((bus.rs1 != '0) && r_busy[bus.rs1]) ||
                      ((bus.rs2 != '0) && r_busy[bus.rs2]);

endmodule
